id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the RV32 core.
- Captures decoded fields from ID each cycle and presents them as ID_REG_* to operand forwarding and EX.
- Contains the load-use interlock: when a load in ID_REG feeds the instruction in ID, it inserts a one-cycle bubble and stalls IF/ID. Forwarding from MEM then resolves the operand.
- Also handles branch/jump flush, external whole-pipe freeze, and a load-use stall event counter.

Parameters:
CTRL_W, 16, width of opaque EX/MEM/WB control bundle (ALU op, mem size, wb select...); bubble value is all-zero.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
ID_valid  input  1  ID holds a real instruction
ID_pc  input  32  PC of ID instruction
ID_imm  input  32  decoded immediate
ID_rs1, ID_rs2  input  5  source register indices
ID_rs1_used, ID_rs2_used  input  1  instruction actually reads rs1/rs2
ID_rd  input  5  destination index
ID_rd_vld  input  1  instruction writes rd
ID_csr  input  12  CSR address
ID_csr_vld  input  1  instruction writes CSR
ID_is_load  input  1  instruction is a load
ID_ctrl  input  CTRL_W  control bundle
EX_flush  input  1  taken branch/jump/trap from EX; kill ID instruction
pipe_freeze  input  1  whole-pipeline hold (MEM busy)
ID_REG_valid  output  1  registered valid
ID_REG_pc, ID_REG_imm  output  32  registered fields
ID_REG_rs1, ID_REG_rs2, ID_REG_rd  output  5  registered indices
ID_REG_rd_vld, ID_REG_csr_vld, ID_REG_is_load  output  1  registered flags
ID_REG_csr  output  12  registered CSR address
ID_REG_ctrl  output  CTRL_W  registered control bundle
hz_stall  output  1  combinational; hold PC and IF/ID register this cycle
hz_cnt  output  32  count of load-use bubbles inserted

Behaviour:
- Reset (async, rst=1):
  - All ID_REG_* = 0, so ID_REG_valid=0 and all flags 0 (bubble).
  - hz_cnt=0.
  - hz_stall depends only on current registered state and inputs; after reset it is 0.
- Load-use condition, combinational:
  - load_use = ID_valid & ID_REG_valid & ID_REG_is_load & (ID_REG_rd!=0) & ((ID_rs1_used & ID_rs1==ID_REG_rd) | (ID_rs2_used & ID_rs2==ID_REG_rd)).
  - x0 never creates a hazard.
  - Unused sources never create a hazard.
  - CSR reads never create a load-use hazard.
- Per-cycle update on clk rising edge, priority highest first:
  1. pipe_freeze=1: all registers hold, hz_cnt holds. EX_flush is ignored this cycle; EX is frozen, so it re-asserts flush next cycle.
  2. EX_flush=1: load bubble (all fields 0), including when load_use=1. No count.
  3. load_use=1: load bubble, hz_cnt += 1 (wraps 0xFFFFFFFF -> 0).
  4. Otherwise: capture all ID_* fields. ID_REG_valid=ID_valid. Fields are captured even when ID_valid=0; all flag outputs are gated to 0 when ID_valid=0.
- hz_stall = pipe_freeze | (load_use & ~EX_flush).
  - Flush wins over load-use, because the ID instruction is wrong-path.
- Load-use stall lasts exactly one cycle: the inserted bubble clears ID_REG_is_load, so load_use deasserts next cycle.
  - Two back-to-back dependent instructions after one load: only the first stalls.
- A load followed by a load that uses its result stalls once. The second load then becomes the new ID_REG load for the following instruction.
- Latency: ID -> ID_REG is one cycle; there is no combinational path from ID_* to ID_REG_*.
- Reset asserted mid-stall: registers clear immediately; hz_stall drops, since ID_REG_valid=0.

Test Plan:
- Reset, then ID_valid=1, pc=0x100, rd=5, rd_vld=1, ctrl=0x00A5 -> next cycle ID_REG_pc=0x100, ID_REG_rd=5, ID_REG_valid=1, hz_stall=0.
- ID_REG holds load with rd=7; ID has rs2=7, rs2_used=1 -> hz_stall=1 for one cycle; next ID_REG_valid=0, hz_cnt=1. The following cycle captures the ID instruction with hz_stall=0.
- Load-use with rd=0 (load x0) and ID rs1=0; then rd=7 with ID rs1=7 but rs1_used=0 -> hz_stall=0 in both cases and hz_cnt unchanged.
- load_use and EX_flush in the same cycle -> hz_stall=0, next ID_REG all zero, hz_cnt unchanged.
- pipe_freeze=1 for 3 cycles with EX_flush=1 and changing ID inputs -> ID_REG_* unchanged throughout, hz_stall=1. Release freeze with EX_flush=1 -> bubble loaded.
- Preload hz_cnt to 0xFFFFFFFF (force via 2^32 hazards, or a backdoor in the bench), trigger one load-use -> hz_cnt=0. Assert rst mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// Bundle of the decoded ID-stage fields and their registered ID_REG copies.
// The master drives the decoded instruction; the slave (pipeline register) returns ID_REG_*.
interface id_ex_reg_if #(
  parameter int CTRL_W = 16
);
  logic              ID_valid;
  logic [31:0]       ID_pc;
  logic [31:0]       ID_imm;
  logic [4:0]        ID_rs1;
  logic [4:0]        ID_rs2;
  logic              ID_rs1_used;
  logic              ID_rs2_used;
  logic [4:0]        ID_rd;
  logic              ID_rd_vld;
  logic [11:0]       ID_csr;
  logic              ID_csr_vld;
  logic              ID_is_load;
  logic [CTRL_W-1:0] ID_ctrl;

  logic              ID_REG_valid;
  logic [31:0]       ID_REG_pc;
  logic [31:0]       ID_REG_imm;
  logic [4:0]        ID_REG_rs1;
  logic [4:0]        ID_REG_rs2;
  logic [4:0]        ID_REG_rd;
  logic              ID_REG_rd_vld;
  logic [11:0]       ID_REG_csr;
  logic              ID_REG_csr_vld;
  logic              ID_REG_is_load;
  logic [CTRL_W-1:0] ID_REG_ctrl;

  modport master (
    output ID_valid, ID_pc, ID_imm, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
           ID_rd, ID_rd_vld, ID_csr, ID_csr_vld, ID_is_load, ID_ctrl,
    input  ID_REG_valid, ID_REG_pc, ID_REG_imm, ID_REG_rs1, ID_REG_rs2, ID_REG_rd,
           ID_REG_rd_vld, ID_REG_csr, ID_REG_csr_vld, ID_REG_is_load, ID_REG_ctrl
  );

  modport slave (
    input  ID_valid, ID_pc, ID_imm, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
           ID_rd, ID_rd_vld, ID_csr, ID_csr_vld, ID_is_load, ID_ctrl,
    output ID_REG_valid, ID_REG_pc, ID_REG_imm, ID_REG_rs1, ID_REG_rs2, ID_REG_rd,
           ID_REG_rd_vld, ID_REG_csr, ID_REG_csr_vld, ID_REG_is_load, ID_REG_ctrl
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use interlock, branch flush, whole-pipe freeze
// and a counter of inserted load-use bubbles.
module id_ex_reg #(
  parameter int CTRL_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_reg_if.slave  bus,
  input  logic        EX_flush,
  input  logic        pipe_freeze,
  output logic        hz_stall,
  output logic [31:0] hz_cnt
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              rd_vld;
    logic [11:0]       csr;
    logic              csr_vld;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;

  stage_t      stage_reg;
  stage_t      stage_next;
  stage_t      captured;
  logic [31:0] hz_cnt_reg;
  logic        cnt_inc;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        load_use;

  // Only sources the instruction really reads can collide with the pending load.
  always_comb begin
    rs1_hit  = bus.ID_rs1_used && (bus.ID_rs1 == stage_reg.rd);
    rs2_hit  = bus.ID_rs2_used && (bus.ID_rs2 == stage_reg.rd);
    load_use = bus.ID_valid && stage_reg.valid && stage_reg.is_load &&
               (stage_reg.rd != 5'd0) && (rs1_hit || rs2_hit);
    hz_stall = pipe_freeze || (load_use && !EX_flush);
  end

  // Fields are taken as-is; flags are qualified so a non-valid slot never acts.
  always_comb begin
    captured.valid   = bus.ID_valid;
    captured.pc      = bus.ID_pc;
    captured.imm     = bus.ID_imm;
    captured.rs1     = bus.ID_rs1;
    captured.rs2     = bus.ID_rs2;
    captured.rd      = bus.ID_rd;
    captured.rd_vld  = bus.ID_rd_vld && bus.ID_valid;
    captured.csr     = bus.ID_csr;
    captured.csr_vld = bus.ID_csr_vld && bus.ID_valid;
    captured.is_load = bus.ID_is_load && bus.ID_valid;
    captured.ctrl    = bus.ID_ctrl;
  end

  // Freeze beats flush (EX re-asserts it once unfrozen); flush beats load-use.
  always_comb begin
    stage_next = stage_reg;
    cnt_inc    = 1'b0;
    if (!pipe_freeze) begin
      if (EX_flush) begin
        stage_next = '0;
      end else if (load_use) begin
        stage_next = '0;
        cnt_inc    = 1'b1;
      end else begin
        stage_next = captured;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg  <= '0;
      hz_cnt_reg <= '0;
    end else begin
      stage_reg <= stage_next;
      if (cnt_inc) begin
        hz_cnt_reg <= hz_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.ID_REG_valid   = stage_reg.valid;
  assign bus.ID_REG_pc      = stage_reg.pc;
  assign bus.ID_REG_imm     = stage_reg.imm;
  assign bus.ID_REG_rs1     = stage_reg.rs1;
  assign bus.ID_REG_rs2     = stage_reg.rs2;
  assign bus.ID_REG_rd      = stage_reg.rd;
  assign bus.ID_REG_rd_vld  = stage_reg.rd_vld;
  assign bus.ID_REG_csr     = stage_reg.csr;
  assign bus.ID_REG_csr_vld = stage_reg.csr_vld;
  assign bus.ID_REG_is_load = stage_reg.is_load;
  assign bus.ID_REG_ctrl    = stage_reg.ctrl;
  assign hz_cnt             = hz_cnt_reg;

endmodule
